// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver that reassembles byte pairs into 12-bit ADC samples and streams them with valid/ready.
// Optional: define UART_RX_MAJORITY_EN for 3-sample majority voting on start/data/stop bits.
module uart_frame_receiver #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned BAUD          = 115_200,
  parameter int unsigned FRAME_SAMPLES = 32,
  parameter int unsigned TIMEOUT_BITS  = 20
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        rx,
  output logic [11:0] sample_data,
  output logic [4:0]  sample_idx,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        frame_done,
  output logic        frame_err,
  output logic        pad_err,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 2);
  localparam int unsigned TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TMO_W        = $clog2(TMO_LIMIT + 1);
  localparam logic [4:0]  LAST_IDX     = 5'(FRAME_SAMPLES - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic {F_LO, F_HI} frame_state_t;

  rx_state_t    rx_state, rx_next;
  frame_state_t frame_state, frame_next;

  logic             rx_m, rx_s, bit_val;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_byte, lo_byte;
  logic [4:0]       samp_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             start_ok, byte_strobe, stop_err, tmo_hit, accept, bit_done, start_done;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Decision taken one cycle past the centre so rx_s/rx_d1/rx_d2 cover centre+1/centre/centre-1.
  localparam int unsigned START_WAIT = CLKS_PER_BIT / 2 + 1;
  logic rx_d1, rx_d2;
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end
  assign bit_val = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  localparam int unsigned START_WAIT = CLKS_PER_BIT / 2;
  assign bit_val = rx_s;
`endif

  assign bit_done   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign start_done = (clk_cnt == CNT_W'(START_WAIT - 1));
  assign accept     = sample_valid & sample_ready;
  assign tmo_hit    = busy && (rx_state == RX_IDLE) && (tmo_cnt == TMO_W'(TMO_LIMIT - 1)) && !byte_strobe;

  always_comb begin
    rx_next     = rx_state;
    start_ok    = 1'b0;
    byte_strobe = 1'b0;
    stop_err    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (start_done) begin
                  if (!bit_val) begin
                    rx_next  = RX_DATA;
                    start_ok = 1'b1;
                  end else begin
                    rx_next = RX_IDLE;
                  end
                end
      RX_DATA:  if (bit_done && bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_done) begin
                  if (bit_val) begin
                    byte_strobe = 1'b1;
                    rx_next     = RX_IDLE;
                  end else begin
                    stop_err = 1'b1;
                    rx_next  = RX_WAIT_HIGH;
                  end
                end
      RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    frame_next = frame_state;
    if (stop_err || tmo_hit)
      frame_next = F_LO;
    else if (byte_strobe)
      frame_next = (frame_state == F_LO) ? F_HI : F_LO;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
    end else if (!enable) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_next != rx_state || (rx_state == RX_DATA && bit_done))
        clk_cnt <= '0;
      else if (rx_state inside {RX_START, RX_DATA, RX_STOP})
        clk_cnt <= clk_cnt + 1'b1;
      else
        clk_cnt <= '0;
      if (start_ok)
        bit_cnt <= '0;
      else if (rx_state == RX_DATA && bit_done) begin
        bit_cnt <= bit_cnt + 1'b1;
        rx_byte <= {bit_val, rx_byte[7:1]};
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state  <= F_LO;
      lo_byte      <= '0;
      samp_cnt     <= '0;
      tmo_cnt      <= '0;
      sample_data  <= '0;
      sample_idx   <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      pad_err      <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else if (!enable) begin
      frame_state  <= F_LO;
      lo_byte      <= '0;
      samp_cnt     <= '0;
      tmo_cnt      <= '0;
      sample_data  <= '0;
      sample_idx   <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      pad_err      <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      frame_state <= frame_next;
      frame_done  <= 1'b0;
      frame_err   <= stop_err | tmo_hit;

      if (busy && rx_state == RX_IDLE && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      if (accept) begin
        sample_valid <= 1'b0;
        if (sample_idx == LAST_IDX) begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
        end
      end

      if (byte_strobe && frame_state == F_LO)
        lo_byte <= rx_byte;

      // High byte completes a sample; a dropped last sample still closes the frame.
      if (byte_strobe && frame_state == F_HI) begin
        pad_err <= pad_err | (|rx_byte[7:4]);
        if (!sample_valid || accept) begin
          sample_valid <= 1'b1;
          sample_data  <= {rx_byte[3:0], lo_byte};
          sample_idx   <= samp_cnt;
        end else begin
          overrun <= 1'b1;
          if (samp_cnt == LAST_IDX) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        samp_cnt <= (samp_cnt == LAST_IDX) ? '0 : samp_cnt + 1'b1;
      end

      if (stop_err || tmo_hit) begin
        samp_cnt <= '0;
        busy     <= 1'b0;
      end

      if (start_ok)
        busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver: full frames, pad/overrun flags, stop error, timeout, reset/enable abort.
module tb_uart_frame_receiver;

  localparam int CPB = 16;
  localparam int TMO = 20 * CPB;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b1;
  logic        rx     = 1'b1;
  logic        sample_ready = 1'b1;
  logic [11:0] sample_data;
  logic [4:0]  sample_idx;
  logic        sample_valid, frame_done, frame_err, pad_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int acc_idx[$];
  int acc_data[$];

  uart_frame_receiver #(
    .CLK_HZ(1_600_000),
    .BAUD(100_000),
    .FRAME_SAMPLES(32),
    .TIMEOUT_BITS(20)
  ) dut (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .enable(enable),
    .rx(rx),
    .sample_data(sample_data),
    .sample_idx(sample_idx),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .pad_err(pad_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  // Inputs change at posedge+2, so at the negedge valid&ready is exactly what the next edge accepts.
  always @(negedge sysclk) begin
    cyc++;
    if (sample_valid && sample_ready) begin
      acc_idx.push_back(int'(sample_idx));
      acc_data.push_back(int'(sample_data));
    end
    if (frame_done) done_cnt++;
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop_bit;
    wait_cyc(CPB);
    rx = 1'b1;
  endtask

  task automatic send_byte_glitch(input logic [7:0] b);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB / 2);
      rx = ~b[i];
      wait_cyc(1);
      rx = b[i];
      wait_cyc(CPB - CPB / 2 - 1);
    end
    rx = 1'b1;
    wait_cyc(CPB);
  endtask

  function automatic logic [31:0] outs();
    return {12'(sample_data), 12'(sample_idx), sample_valid, frame_done, frame_err,
            pad_err, overrun, busy, 2'b00};
  endfunction

  initial begin
    int b0, e0, d0, t_end, delta;

    // Reset state
    wait_cyc(3);
    check("reset_outputs", outs(), 32'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    // 1: clean frame, samples 0x000..0x01F
    b0 = acc_idx.size(); d0 = done_cnt; e0 = err_cnt;
    for (int s = 0; s < 32; s++) begin
      send_byte(8'(s), 1'b1);
      send_byte(8'h00, 1'b1);
    end
    wait_cyc(20);
    check("f1_count", 32'(acc_idx.size() - b0), 32'd32);
    for (int i = b0; i < acc_idx.size(); i++) begin
      check("f1_idx", 32'(acc_idx[i]), 32'(i - b0));
      check("f1_data", 32'(acc_data[i]), 32'(i - b0));
    end
    check("f1_done", 32'(done_cnt - d0), 32'd1);
    check("f1_err", 32'(err_cnt - e0), 32'd0);
    check("f1_flags", {30'd0, pad_err, overrun}, 32'd0);
    check("f1_busy", 32'(busy), 32'd0);

    // 4: stop bit error on byte 10
    b0 = acc_idx.size(); e0 = err_cnt;
    for (int k = 0; k < 10; k++) send_byte((k % 2 == 0) ? 8'(k / 2) : 8'h00, 1'b1);
    check("se_busy_before", 32'(busy), 32'd1);
    send_byte(8'h55, 1'b0);
    wait_cyc(3 * CPB);
    check("se_err_pulse", 32'(err_cnt - e0), 32'd1);
    check("se_busy", 32'(busy), 32'd0);
    check("se_count", 32'(acc_idx.size() - b0), 32'd5);

    // 3: next clean frame restarts at 0; ready low over samples 5..6
    b0 = acc_idx.size(); d0 = done_cnt;
    for (int s = 0; s < 32; s++) begin
      send_byte(8'(s), 1'b1);
      if (s == 5) sample_ready = 1'b0;
      send_byte(8'h00, 1'b1);
      if (s == 5) begin
        wait_cyc(4);
        check("ov_hold5", {8'd0, 12'(sample_data), 5'd0, sample_idx, sample_valid, overrun},
              {8'd0, 12'h005, 5'd0, 5'd5, 1'b1, 1'b0});
      end
      if (s == 6) begin
        wait_cyc(4);
        check("ov_hold6", {8'd0, 12'(sample_data), 5'd0, sample_idx, sample_valid, overrun},
              {8'd0, 12'h005, 5'd0, 5'd5, 1'b1, 1'b1});
        sample_ready = 1'b1;
      end
    end
    wait_cyc(20);
    check("ov_count", 32'(acc_idx.size() - b0), 32'd31);
    for (int i = b0; i < acc_idx.size(); i++) begin
      check("ov_idx", 32'(acc_idx[i]), (i - b0 < 6) ? 32'(i - b0) : 32'(i - b0 + 1));
      check("ov_data", 32'(acc_data[i]), 32'(acc_idx[i]));
    end
    check("ov_done", 32'(done_cnt - d0), 32'd1);
    check("ov_sticky", 32'(overrun), 32'd1);
    check("ov_busy", 32'(busy), 32'd0);

    // 5: 7 bytes then idle -> timeout
    b0 = acc_idx.size(); e0 = err_cnt;
    for (int k = 0; k < 7; k++) send_byte((k % 2 == 0) ? 8'(8'h11 * (k / 2 + 1)) : 8'h00, 1'b1);
    t_end = cyc;
    wait_cyc(21 * CPB);
    delta = err_cyc - t_end;
    check("tmo_pulse", 32'(err_cnt - e0), 32'd1);
    check("tmo_window", 32'(delta >= TMO - 30 && delta <= TMO + 10), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_count", 32'(acc_idx.size() - b0), 32'd3);
    if (acc_idx.size() - b0 == 3)
      check("tmo_data2", 32'(acc_data[b0 + 2]), 32'h33);

    // 5: quarter-bit glitch on idle line
    b0 = acc_idx.size(); e0 = err_cnt;
    rx = 1'b0;
    wait_cyc(CPB / 4);
    rx = 1'b1;
    wait_cyc(2);
    check("gl_busy_mid", 32'(busy), 32'd0);
    wait_cyc(2 * CPB);
    check("gl_busy", 32'(busy), 32'd0);
    check("gl_none", 32'(acc_idx.size() - b0), 32'd0);
    check("gl_no_err", 32'(err_cnt - e0), 32'd0);

    // 2: sample reassembly and pad error; frame restarts at idx 0 after the timeout
    b0 = acc_idx.size();
    send_byte(8'hAB, 1'b1);
    send_byte(8'h0C, 1'b1);
    wait_cyc(4);
    check("pair1_pad", 32'(pad_err), 32'd0);
    send_byte(8'h34, 1'b1);
    send_byte(8'hF2, 1'b1);
    wait_cyc(4);
    check("pair_count", 32'(acc_idx.size() - b0), 32'd2);
    if (acc_idx.size() - b0 == 2) begin
      check("pair1_idx", 32'(acc_idx[b0]), 32'd0);
      check("pair1_data", 32'(acc_data[b0]), 32'hCAB);
      check("pair2_idx", 32'(acc_idx[b0 + 1]), 32'd1);
      check("pair2_data", 32'(acc_data[b0 + 1]), 32'h234);
    end
    check("pair2_pad", 32'(pad_err), 32'd1);
    e0 = err_cnt;
    wait_cyc(22 * CPB);
    check("pad_sticky", 32'(pad_err), 32'd1);
    check("pair_tmo", 32'(err_cnt - e0), 32'd1);

    // 6: reset mid-byte 3
    sample_ready = 1'b0;
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h00, 1'b1);
    rx = 1'b0;
    wait_cyc(CPB + 4);
    rx = 1'b1;
    wait_cyc(10);
    check("rst_pre", {28'd0, sample_valid, busy, overrun, pad_err}, 32'hF);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", outs(), 32'h0);
    wait_cyc(2);
    rst_n = 1'b1;
    sample_ready = 1'b1;
    wait_cyc(3 * CPB);
    b0 = acc_idx.size();
    send_byte(8'h07, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_cyc(4);
    check("rst_after_count", 32'(acc_idx.size() - b0), 32'd1);
    if (acc_idx.size() - b0 == 1)
      check("rst_after", {16'(acc_idx[b0]), 16'(acc_data[b0])}, {16'd0, 16'h007});

    // 6: enable low mid-frame
    e0 = err_cnt;
    sample_ready = 1'b0;
    send_byte(8'h34, 1'b1);
    send_byte(8'hF2, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    check("en_pre", {28'd0, sample_valid, busy, overrun, pad_err}, 32'hF);
    enable = 1'b0;
    wait_cyc(1);
    check("en_outputs", outs(), 32'h0);
    wait_cyc(4);
    check("en_no_err", 32'(err_cnt - e0), 32'd0);
    enable = 1'b1;
    sample_ready = 1'b1;
    wait_cyc(2 * CPB);
    b0 = acc_idx.size();
    send_byte(8'h09, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_cyc(4);
    check("en_after_count", 32'(acc_idx.size() - b0), 32'd1);
    if (acc_idx.size() - b0 == 1)
      check("en_after", {16'(acc_idx[b0]), 16'(acc_data[b0])}, {16'd0, 16'h009});

`ifdef UART_RX_MAJORITY_EN
    b0 = acc_idx.size();
    send_byte_glitch(8'hA5);
    send_byte_glitch(8'h03);
    wait_cyc(4);
    check("maj_count", 32'(acc_idx.size() - b0), 32'd1);
    if (acc_idx.size() - b0 == 1)
      check("maj_data", 32'(acc_data[b0]), 32'h3A5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
